// File: rtl/wash_phase_timer_if.sv
// Interface between the washing-machine controller and its sensor/timer stage.
// master : controller side, drives actuator commands, abort and the raw level sample.
// slave  : timer side, returns filled/drained, cycle/spin timeouts, phase_count and busy.
interface wash_phase_if #(
    parameter int CNT_W = 16,
    parameter int LVL_W = 8
) ();
    logic             motor_on;
    logic             fill_value_on;
    logic             drain_value_on;
    logic             soap_wash;
    logic             water_wash;
    logic             abort;
    logic [LVL_W-1:0] water_level;
    logic             filled;
    logic             drained;
    logic             cycle_timeout;
    logic             spin_timeout;
    logic [CNT_W-1:0] phase_count;
    logic             busy;

    modport master (
        output motor_on, fill_value_on, drain_value_on, soap_wash, water_wash, abort, water_level,
        input  filled, drained, cycle_timeout, spin_timeout, phase_count, busy
    );

    modport slave (
        input  motor_on, fill_value_on, drain_value_on, soap_wash, water_wash, abort, water_level,
        output filled, drained, cycle_timeout, spin_timeout, phase_count, busy
    );
endinterface

// File: rtl/wash_phase_timer.sv
// Sensor/timer stage for the automatic washing machine controller.
// Times wash/rinse agitation and spin phases from the controller's actuator outputs and
// debounces the raw water-level sensor into filled/drained.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      wash_phase_if.slave: actuator commands, abort and water_level in;
//            filled, drained, cycle_timeout, spin_timeout, phase_count, busy out (all registered)
module wash_phase_timer #(
    parameter int WASH_CYCLES  = 16,
    parameter int RINSE_CYCLES = 12,
    parameter int SPIN_CYCLES  = 8,
    parameter int CNT_W        = 16,
    parameter int LVL_W        = 8,
    parameter int FULL_LEVEL   = 200,
    parameter int EMPTY_LEVEL  = 10,
    parameter int DEBOUNCE     = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    wash_phase_if.slave  bus
);
    localparam logic [CNT_W-1:0] WASH_LIM  = CNT_W'(WASH_CYCLES);
    localparam logic [CNT_W-1:0] RINSE_LIM = CNT_W'(RINSE_CYCLES);
    localparam logic [CNT_W-1:0] SPIN_LIM  = CNT_W'(SPIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FULL_LEVEL);
    localparam logic [LVL_W-1:0] EMPTY_LVL = LVL_W'(EMPTY_LEVEL);
    localparam int               DB_W      = $clog2(DEBOUNCE + 1);
    localparam logic [DB_W-1:0]  DB_MAX    = DB_W'(DEBOUNCE - 1);

    typedef enum logic [2:0] {
        T_IDLE      = 3'd0,
        T_WASH      = 3'd1,
        T_WASH_DONE = 3'd2,
        T_SPIN      = 3'd3,
        T_SPIN_DONE = 3'd4
    } state_t;

    state_t           state_r, state_nx_s;
    logic [CNT_W-1:0] count_r, count_nx_s;
    logic [CNT_W-1:0] lim_r, lim_nx_s, entry_lim_s;
    logic             soap_r, soap_nx_s;
    logic             wash_ph_s, spin_ph_s;
    logic             cycle_timeout_r, spin_timeout_r, busy_r;
    logic             full_s, empty_s;
    logic             filled_r, drained_r;
    logic [DB_W-1:0]  fill_db_r, drain_db_r;

    // Phase decode from actuator commands; wash and spin are exclusive via drain_value_on.
    always_comb begin
        wash_ph_s   = bus.motor_on & ~bus.drain_value_on & (bus.soap_wash | bus.water_wash);
        spin_ph_s   = bus.motor_on & bus.drain_value_on;
        entry_lim_s = bus.soap_wash ? WASH_LIM : RINSE_LIM;
        full_s      = (bus.water_level >= FULL_LVL);
        empty_s     = (bus.water_level <= EMPTY_LVL);
    end

    // Next-state logic for the phase FSM. Entering a phase loads count=1 so the
    // timeout registers on the same edge the count reaches the limit.
    always_comb begin
        state_nx_s = state_r;
        count_nx_s = count_r;
        lim_nx_s   = lim_r;
        soap_nx_s  = soap_r;
        if (bus.abort) begin
            state_nx_s = T_IDLE;
            count_nx_s = '0;
        end else begin
            case (state_r)
                T_IDLE, T_WASH, T_WASH_DONE, T_SPIN, T_SPIN_DONE: begin
                    if (wash_ph_s) begin
                        if ((state_r == T_WASH || state_r == T_WASH_DONE) && (bus.soap_wash == soap_r)) begin
                            // Continuing the same wash type: advance or hold at the limit.
                            if (state_r == T_WASH_DONE) begin
                                state_nx_s = T_WASH_DONE;
                            end else if ((count_r + CNT_ONE) == lim_r) begin
                                state_nx_s = T_WASH_DONE;
                                count_nx_s = count_r + CNT_ONE;
                            end else begin
                                state_nx_s = T_WASH;
                                count_nx_s = count_r + CNT_ONE;
                            end
                        end else if (state_r == T_WASH_DONE) begin
                            // Type change after completion keeps the completed phase held.
                            state_nx_s = T_WASH_DONE;
                        end else begin
                            // Fresh entry or soap/water flip mid-phase: restart and relatch limit.
                            state_nx_s = (entry_lim_s == CNT_ONE) ? T_WASH_DONE : T_WASH;
                            count_nx_s = CNT_ONE;
                            lim_nx_s   = entry_lim_s;
                            soap_nx_s  = bus.soap_wash;
                        end
                    end else if (spin_ph_s) begin
                        if (state_r == T_SPIN_DONE) begin
                            state_nx_s = T_SPIN_DONE;
                        end else if (state_r == T_SPIN) begin
                            state_nx_s = ((count_r + CNT_ONE) == SPIN_LIM) ? T_SPIN_DONE : T_SPIN;
                            count_nx_s = count_r + CNT_ONE;
                        end else begin
                            state_nx_s = (SPIN_LIM == CNT_ONE) ? T_SPIN_DONE : T_SPIN;
                            count_nx_s = CNT_ONE;
                        end
                    end else begin
                        // No pause/resume: any dropout returns to idle.
                        state_nx_s = T_IDLE;
                        count_nx_s = '0;
                    end
                end
                default: begin
                    state_nx_s = T_IDLE;
                    count_nx_s = '0;
                end
            endcase
        end
    end

    // Phase FSM state, counter and registered phase outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= T_IDLE;
            count_r         <= '0;
            lim_r           <= '0;
            soap_r          <= 1'b0;
            cycle_timeout_r <= 1'b0;
            spin_timeout_r  <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            state_r         <= state_nx_s;
            count_r         <= count_nx_s;
            lim_r           <= lim_nx_s;
            soap_r          <= soap_nx_s;
            cycle_timeout_r <= (state_nx_s == T_WASH_DONE);
            spin_timeout_r  <= (state_nx_s == T_SPIN_DONE);
            busy_r          <= (state_nx_s == T_WASH) || (state_nx_s == T_SPIN);
        end
    end

    // Filled debouncer: counts consecutive samples that disagree with the current output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filled_r  <= 1'b0;
            fill_db_r <= '0;
        end else if (full_s != filled_r) begin
            if (fill_db_r == DB_MAX) begin
                filled_r  <= full_s;
                fill_db_r <= '0;
            end else begin
                fill_db_r <= fill_db_r + DB_W'(1);
            end
        end else begin
            fill_db_r <= '0;
        end
    end

    // Drained debouncer: same scheme on the empty comparison.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drained_r  <= 1'b0;
            drain_db_r <= '0;
        end else if (empty_s != drained_r) begin
            if (drain_db_r == DB_MAX) begin
                drained_r  <= empty_s;
                drain_db_r <= '0;
            end else begin
                drain_db_r <= drain_db_r + DB_W'(1);
            end
        end else begin
            drain_db_r <= '0;
        end
    end

    assign bus.filled        = filled_r;
    assign bus.drained       = drained_r;
    assign bus.cycle_timeout = cycle_timeout_r;
    assign bus.spin_timeout  = spin_timeout_r;
    assign bus.phase_count   = count_r;
    assign bus.busy          = busy_r;
endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed testbench for wash_phase_timer with hand-computed expectations.
module tb_wash_phase_timer;
    logic clk;
    logic reset_n;
    int   n_total;
    int   n_bad;

    wash_phase_if #(.CNT_W(16), .LVL_W(8)) bus_if ();

    wash_phase_timer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] lvl_seq [7];
        n_total = 0;
        n_bad   = 0;
        lvl_seq = '{8'd210, 8'd210, 8'd150, 8'd210, 8'd210, 8'd210, 8'd210};

        // 1: reset with active phase inputs and a full level
        reset_n                = 1'b0;
        bus_if.motor_on        = 1'b1;
        bus_if.fill_value_on   = 1'b0;
        bus_if.drain_value_on  = 1'b0;
        bus_if.soap_wash       = 1'b1;
        bus_if.water_wash      = 1'b0;
        bus_if.abort           = 1'b0;
        bus_if.water_level     = 8'd255;
        #12;
        chk("rst_ct",    32'(bus_if.cycle_timeout), 32'd0);
        chk("rst_spin",  32'(bus_if.spin_timeout),  32'd0);
        chk("rst_fill",  32'(bus_if.filled),        32'd0);
        chk("rst_drain", 32'(bus_if.drained),       32'd0);
        chk("rst_cnt",   32'(bus_if.phase_count),   32'd0);
        chk("rst_busy",  32'(bus_if.busy),          32'd0);
        reset_n = 1'b1;
        repeat (3) tick();
        chk("pre_cnt", 32'(bus_if.phase_count), 32'd3);
        chk("pre_busy", 32'(bus_if.busy), 32'd1);
        #3 reset_n = 1'b0;
        #1;
        chk("async_cnt",  32'(bus_if.phase_count), 32'd0);
        chk("async_busy", 32'(bus_if.busy),        32'd0);
        bus_if.motor_on    = 1'b0;
        bus_if.soap_wash   = 1'b0;
        bus_if.water_level = 8'd0;
        #2 reset_n = 1'b1;
        tick();
        chk("idle_cnt", 32'(bus_if.phase_count), 32'd0);

        // 2: soap wash, timeout after edge 16 and held
        bus_if.motor_on  = 1'b1;
        bus_if.soap_wash = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("soap_cnt", 32'(bus_if.phase_count), (k >= 16) ? 32'd16 : 32'(k));
            chk("soap_ct",  32'(bus_if.cycle_timeout), (k >= 16) ? 32'd1 : 32'd0);
            chk("soap_busy", 32'(bus_if.busy), (k >= 16) ? 32'd0 : 32'd1);
        end
        bus_if.motor_on  = 1'b0;
        bus_if.soap_wash = 1'b0;
        tick();
        chk("soap_off_ct",  32'(bus_if.cycle_timeout), 32'd0);
        chk("soap_off_cnt", 32'(bus_if.phase_count),   32'd0);

        // 3: rinse, then flip to soap restarts the count
        bus_if.motor_on   = 1'b1;
        bus_if.water_wash = 1'b1;
        repeat (5) tick();
        chk("rinse_cnt", 32'(bus_if.phase_count), 32'd5);
        bus_if.soap_wash  = 1'b1;
        bus_if.water_wash = 1'b0;
        tick();
        chk("flip_cnt", 32'(bus_if.phase_count), 32'd1);
        repeat (14) tick();
        chk("flip_cnt15", 32'(bus_if.phase_count),   32'd15);
        chk("flip_ct15",  32'(bus_if.cycle_timeout), 32'd0);
        tick();
        chk("flip_cnt16", 32'(bus_if.phase_count),   32'd16);
        chk("flip_ct16",  32'(bus_if.cycle_timeout), 32'd1);
        bus_if.motor_on  = 1'b0;
        bus_if.soap_wash = 1'b0;
        tick();

        // 4: spin to completion, then an aborted-by-dropout spin
        bus_if.motor_on       = 1'b1;
        bus_if.drain_value_on = 1'b1;
        repeat (7) tick();
        chk("spin7_to",  32'(bus_if.spin_timeout), 32'd0);
        chk("spin7_cnt", 32'(bus_if.phase_count),  32'd7);
        tick();
        chk("spin8_to",   32'(bus_if.spin_timeout),  32'd1);
        chk("spin8_cnt",  32'(bus_if.phase_count),   32'd8);
        chk("spin8_ct",   32'(bus_if.cycle_timeout), 32'd0);
        chk("spin8_busy", 32'(bus_if.busy),          32'd0);
        tick();
        chk("spin_sat", 32'(bus_if.phase_count), 32'd8);
        bus_if.motor_on = 1'b0;
        tick();
        chk("spin_off_to", 32'(bus_if.spin_timeout), 32'd0);
        bus_if.motor_on = 1'b1;
        repeat (4) tick();
        chk("spin4_cnt", 32'(bus_if.phase_count), 32'd4);
        bus_if.motor_on = 1'b0;
        tick();
        chk("spin_drop_cnt",  32'(bus_if.phase_count),  32'd0);
        chk("spin_drop_to",   32'(bus_if.spin_timeout), 32'd0);
        chk("spin_drop_busy", 32'(bus_if.busy),         32'd0);
        bus_if.drain_value_on = 1'b0;

        // 5: level debounce with a glitch
        bus_if.water_level = 8'd0;
        repeat (5) tick();
        chk("lvl0_drain", 32'(bus_if.drained), 32'd1);
        chk("lvl0_fill",  32'(bus_if.filled),  32'd0);
        for (int i = 0; i < 7; i++) begin
            bus_if.water_level = lvl_seq[i];
            tick();
            chk("deb_fill", 32'(bus_if.filled), (i == 6) ? 32'd1 : 32'd0);
        end
        chk("deb_drain_clr", 32'(bus_if.drained), 32'd0);
        bus_if.water_level = 8'd5;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("empty_fill",  32'(bus_if.filled),  (i < 4) ? 32'd1 : 32'd0);
            chk("empty_drain", 32'(bus_if.drained), (i < 4) ? 32'd0 : 32'd1);
        end

        // 6: abort in T_WASH_DONE
        bus_if.water_level = 8'd210;
        repeat (4) tick();
        chk("ab_fill_pre", 32'(bus_if.filled), 32'd1);
        bus_if.motor_on  = 1'b1;
        bus_if.soap_wash = 1'b1;
        repeat (16) tick();
        chk("ab_ct_pre", 32'(bus_if.cycle_timeout), 32'd1);
        bus_if.abort = 1'b1;
        tick();
        chk("ab_ct",   32'(bus_if.cycle_timeout), 32'd0);
        chk("ab_cnt",  32'(bus_if.phase_count),   32'd0);
        chk("ab_busy", 32'(bus_if.busy),          32'd0);
        chk("ab_fill", 32'(bus_if.filled),        32'd1);
        bus_if.abort = 1'b0;
        tick();
        chk("ab_restart_cnt", 32'(bus_if.phase_count), 32'd1);
        bus_if.motor_on  = 1'b0;
        bus_if.soap_wash = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
